chronos_fetch: RTL
==================

Name: chronos_fetch

Overview:
Instruction-fetch (IF) stage of the Chronos 5-stage RV32I pipeline; feeds the decode stage through the IF/ID pipeline register.
- Owns the program counter and drives the word-addressed instruction-memory request.
- Consumes next-PC predictions from the hybrid branch predictor and redirects from EX on mispredict.
- Holds one skid entry so a synchronous 1-cycle instruction memory never loses data when decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous active-high reset.
inst_addr  output  30  word address to instruction memory, equal to pc_q[31:2].
inst_req  output  1  request valid this cycle; memory returns data on inst in the next cycle.
inst  input  32  instruction word for the request issued in the previous cycle.
pred_taken  input  1  predictor says the instruction at pc_q is a taken branch (combinational lookup on pc_q).
pred_target  input  32  predicted target, used when pred_taken=1.
redirect_valid  input  1  EX mispredict or jump; flushes the stage.
redirect_pc  input  32  correct next PC; bits [1:0] are ignored and treated as 0.
id_stall  input  1  decode cannot accept; the IF/ID register holds.
if_valid  output  1  IF/ID entry valid.
if_pc  output  32  PC of the IF/ID instruction.
if_inst  output  32  instruction word.
if_pred_taken  output  1  prediction recorded at request time.
if_pred_target  output  32  predicted target recorded at request time.

Behaviour:
Reset:
- Asynchronous, may assert in any cycle, including mid-stall or with a redirect pending.
- pc_q=RESET_PC; req_valid, skid_valid and if_valid all 0; if_pc, if_inst, if_pred_taken and if_pred_target all 0.

Issue condition:
- issue = !skid_valid && !(id_stall && req_valid).
- inst_req = issue && !rst.
- inst_addr always equals pc_q[31:2].

Next PC, priority order:
1. redirect_valid: {redirect_pc[31:2],2'b00}.
2. !issue: pc_q is held.
3. pred_taken: {pred_target[31:2],2'b00}.
4. Otherwise pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).

Request tracking:
- On issue, the edge captures req_pc=pc_q, req_pt=pred_taken, req_tgt=pred_target, req_valid=1.
- Otherwise req_valid=0.
- Latency: request issued in cycle N; inst is valid in N+1; if_valid=1 from N+2. Steady state with no stall or redirect is 1 instruction per cycle.

Response routing at the end of a cycle with req_valid=1:
- If the IF/ID register is free or advancing (!if_valid || !id_stall) and skid is empty, the response loads IF/ID.
- Otherwise the response loads skid (skid_valid=1).
- The issue rule guarantees skid never overflows.

Advance when !id_stall:
- If skid_valid: IF/ID <= skid and skid_valid=0. A same-cycle response cannot occur, because issue was blocked.
- Else if req_valid: IF/ID <= response.
- Else: if_valid=0.

id_stall=1:
- The IF/ID register holds all fields unchanged.

redirect_valid=1 (dominates id_stall and all other events):
- At the edge, if_valid, skid_valid and req_valid become 0. The in-flight response is discarded.
- pc_q is loaded with the redirect target. The first fetch of the target is issued the next cycle; its if_valid appears 2 cycles after that.

Data hygiene:
- Output data fields may hold stale values when if_valid=0.
- Decode must qualify all fields with if_valid.

Test Plan:
1. Reset release, RESET_PC=0x100, memory returns addr*4, no stall. Required: inst_addr 0x40, 0x41, 0x42 on consecutive cycles; if_valid rises 2 cycles after the first request; if_pc 0x100, 0x104, 0x108 with matching if_inst.
2. pred_taken=1 with pred_target=0x200 while pc_q=0x108. Required: the next inst_addr is 0x80; the 0x108 entry carries if_pred_taken=1 and if_pred_target=0x200; the following if_pc is 0x200.
3. id_stall held high for 3 cycles while a request is in flight. Required:
   - The IF/ID register is frozen.
   - The response lands in skid and inst_req drops.
   - On release, if_pc steps through the held entry, then the skid entry, then fetch resumes with no lost or duplicated PC.
4. redirect_valid with redirect_pc=0x403, asserted together with id_stall=1 and skid full. Required: all valids clear at the edge; the next inst_addr is 0x100 (0x400>>2); the first new if_pc is 0x400.
5. pc_q=0xFFFF_FFFC with no prediction. Required: the next inst_addr is 0x0, and the PC wraps to 0.
6. rst asserted mid-stream with skid_valid=1. Required: outputs go to 0 immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/chronos_fetch.sv
// IF stage: owns the PC and fetches from a 1-cycle synchronous imem (issue N, if_valid from N+2; 1 instr/cycle steady).
// Backpressure: id_stall freezes IF/ID, one skid entry catches the in-flight response, then issue stops until skid drains.
module chronos_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-3:0] inst_addr,
    output logic            inst_req,
    input  logic [31:0]     inst,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    logic            req_valid;
    logic [XLEN-1:0] req_pc;
    logic            req_pt;
    logic [XLEN-1:0] req_tgt;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_inst;
    logic            skid_pt;
    logic [XLEN-1:0] skid_tgt;

    logic issue;
    logic resp_to_if;
    logic resp_to_skid;
    logic skid_drain;

    // Issue is blocked whenever the response could have nowhere to go.
    always_comb begin
        issue        = !skid_valid && !(id_stall && req_valid);
        inst_req     = issue && !rst;
        inst_addr    = pc_q[XLEN-1:2];
        skid_drain   = skid_valid && !id_stall;
        resp_to_if   = req_valid && !skid_valid && (!if_valid || !id_stall);
        resp_to_skid = req_valid && !resp_to_if;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
        end else if (!issue) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target & ALIGN_MASK;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC & ALIGN_MASK;
            req_valid <= 1'b0;
            req_pc    <= '0;
            req_pt    <= 1'b0;
            req_tgt   <= '0;
        end else begin
            pc_q      <= pc_d;
            req_valid <= issue && !redirect_valid;
            if (issue) begin
                req_pc  <= pc_q;
                req_pt  <= pred_taken;
                req_tgt <= pred_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            skid_pt    <= 1'b0;
            skid_tgt   <= '0;
        end else if (redirect_valid) begin
            skid_valid <= 1'b0;
        end else if (skid_drain) begin
            skid_valid <= 1'b0;
        end else if (resp_to_skid) begin
            skid_valid <= 1'b1;
            skid_pc    <= req_pc;
            skid_inst  <= inst;
            skid_pt    <= req_pt;
            skid_tgt   <= req_tgt;
        end
    end

    // Skid content is older than any response, so it drains first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_inst        <= '0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (skid_drain) begin
            if_valid       <= 1'b1;
            if_pc          <= skid_pc;
            if_inst        <= skid_inst;
            if_pred_taken  <= skid_pt;
            if_pred_target <= skid_tgt;
        end else if (resp_to_if) begin
            if_valid       <= 1'b1;
            if_pc          <= req_pc;
            if_inst        <= inst;
            if_pred_taken  <= req_pt;
            if_pred_target <= req_tgt;
        end else if (!id_stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule
